// File: rtl/display_scan_sequencer.sv
// display_scan_sequencer: time-multiplexes an 8-digit seven-segment display.
// Each digit slot is DIV = CLK_HZ/SCAN_HZ cycles long. The slot opens with
// BLANK_CYCLES of all-anodes-off, followed by the DRIVE phase, during which the
// selected digit's active-low anode is pulled low if its mask bit is set.
// Every output is registered from the current state. As a result, the outputs
// lag the state register by one cycle, except that en=0 forces them dark
// immediately.
// Optional feature macro: DISP_DIM_EN. When it is defined, a 4-bit PWM gates the
// anode by the brightness value.
module display_scan_sequencer #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 480,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] digit_mask,
  input  logic [3:0] bright,
  output logic [7:0] anode,
  output logic [2:0] seg_sel,
  output logic       scan_tick,
  output logic       frame_done
);

  // DIV must exceed BLANK_CYCLES+16 so that every slot has a real DRIVE phase.
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] SLOT_LAST  = PW'(DIV - 1);
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    digit_q, digit_d;
  logic [7:0]    mask_q, mask_d;
  logic          wrap_q, wrap_d;
  logic [7:0]    anode_q, anode_d;
  logic [2:0]    seg_sel_q, seg_sel_d;
  logic          scan_tick_q, scan_tick_d;
  logic          frame_done_q, frame_done_d;
  logic          lit_s;

`ifdef DISP_DIM_EN
  logic [3:0]    pwm_q, pwm_d;
  logic [3:0]    bright_q, bright_d;
`else
  logic          bright_unused_s;
  assign bright_unused_s = ^bright;
`endif

  // Next-state logic: slot sequencing, prescaler and the entry latches for DRIVE.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    digit_d = digit_q;
    mask_d  = mask_q;
    wrap_d  = 1'b0;
`ifdef DISP_DIM_EN
    pwm_d    = pwm_q;
    bright_d = bright_q;
`endif
    if (!en) begin
      state_d = IDLE;
      presc_d = '0;
      digit_d = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          presc_d = '0;
          digit_d = 3'd0;
        end
        BLANK: begin
          presc_d = presc_q + PW'(1);
          if (presc_q == BLANK_LAST) begin
            state_d = DRIVE;
            mask_d  = digit_mask;
`ifdef DISP_DIM_EN
            pwm_d    = 4'd0;
            bright_d = bright;
`endif
          end else begin
            state_d = BLANK;
          end
        end
        DRIVE: begin
          if (presc_q == SLOT_LAST) begin
            state_d = BLANK;
            presc_d = '0;
            digit_d = digit_q + 3'd1;
            wrap_d  = (digit_q == 3'd7);
          end else begin
            presc_d = presc_q + PW'(1);
`ifdef DISP_DIM_EN
            pwm_d   = pwm_q + 4'd1;
`endif
          end
        end
        default: begin
          state_d = IDLE;
          presc_d = '0;
          digit_d = 3'd0;
        end
      endcase
    end
  end

  // Output decode from the current state. en=0 forces the display dark at once.
  always_comb begin
`ifdef DISP_DIM_EN
    lit_s = mask_q[digit_q] && (pwm_q < bright_q);
`else
    lit_s = mask_q[digit_q];
`endif
    anode_d = 8'hFF;
    if (en && (state_q == DRIVE) && lit_s) begin
      anode_d[digit_q] = 1'b0;
    end else begin
      anode_d = 8'hFF;
    end
    seg_sel_d    = en ? digit_q : 3'd0;
    scan_tick_d  = en && (state_q == BLANK) && (presc_q == '0);
    frame_done_d = scan_tick_d && wrap_q;
  end

  // All state and output registers. Reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      digit_q      <= 3'd0;
      mask_q       <= 8'h00;
      wrap_q       <= 1'b0;
      anode_q      <= 8'hFF;
      seg_sel_q    <= 3'd0;
      scan_tick_q  <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef DISP_DIM_EN
      pwm_q        <= 4'd0;
      bright_q     <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      digit_q      <= digit_d;
      mask_q       <= mask_d;
      wrap_q       <= wrap_d;
      anode_q      <= anode_d;
      seg_sel_q    <= seg_sel_d;
      scan_tick_q  <= scan_tick_d;
      frame_done_q <= frame_done_d;
`ifdef DISP_DIM_EN
      pwm_q        <= pwm_d;
      bright_q     <= bright_d;
`endif
    end
  end

  assign anode      = anode_q;
  assign seg_sel    = seg_sel_q;
  assign scan_tick  = scan_tick_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_sequencer.sv
// Testbench for display_scan_sequencer. The configuration is DIV=100 and
// BLANK_CYCLES=4. A slot-arithmetic reference model predicts every output
// under random enable, mask and brightness stimulus.
module tb_display_scan_sequencer;

  localparam int CLK_HZ  = 48_000;
  localparam int SCAN_HZ = 480;
  localparam int BLANKC  = 4;
  localparam int DIV     = CLK_HZ / SCAN_HZ;

  logic       clk;
  logic       reset;
  logic       en;
  logic [7:0] digit_mask;
  logic [3:0] bright;
  logic [7:0] anode;
  logic [2:0] seg_sel;
  logic       scan_tick;
  logic       frame_done;

  int checks_cnt;
  int fail_cnt;

  // Reference model state: cycles since the enable edge, plus the mask and
  // brightness captured for the current slot.
  bit         m_active;
  int         m_k;
  logic [7:0] m_mask;
  logic [3:0] m_bright;
  logic [7:0] exp_anode;
  logic [2:0] exp_seg;
  logic       exp_tick;
  logic       exp_fd;

  display_scan_sequencer #(
    .CLK_HZ(CLK_HZ),
    .SCAN_HZ(SCAN_HZ),
    .BLANK_CYCLES(BLANKC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .digit_mask(digit_mask),
    .bright(bright),
    .anode(anode),
    .seg_sel(seg_sel),
    .scan_tick(scan_tick),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
    end
  endtask

  // Advance the model by one rising edge, using the inputs as sampled at that edge.
  task automatic model_edge();
    int j;
    int slot;
    int off;
    int dig;
    logic [7:0] lit_mask;
    exp_anode = 8'hFF;
    exp_seg   = 3'd0;
    exp_tick  = 1'b0;
    exp_fd    = 1'b0;
    if (!reset || !en) begin
      m_active = 1'b0;
      m_k      = 0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_k      = 0;
    end else begin
      m_k++;
    end
    if (reset && en && m_k >= 1) begin
      j    = m_k - 1;
      slot = j / DIV;
      off  = j % DIV;
      dig  = slot % 8;
      if (off == BLANKC - 1) begin
        m_mask   = digit_mask;
        m_bright = bright;
      end
      exp_seg  = 3'(dig);
      exp_tick = (off == 0);
      exp_fd   = (off == 0) && (slot > 0) && (dig == 0);
      lit_mask = m_mask;
      if (off >= BLANKC && lit_mask[dig]) begin
`ifdef DISP_DIM_EN
        if (((off - BLANKC) % 16) < int'(m_bright)) exp_anode[dig] = 1'b0;
`else
        exp_anode[dig] = 1'b0;
`endif
      end
    end
  endtask

  // One clock cycle: update the model at the rising edge, then compare at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk_eq("anode", 32'(anode), 32'(exp_anode));
    chk_eq("seg_sel", 32'(seg_sel), 32'(exp_seg));
    chk_eq("scan_tick", 32'(scan_tick), 32'(exp_tick));
    chk_eq("frame_done", 32'(frame_done), 32'(exp_fd));
  endtask

  initial begin
    int ticks;
    int fds;
    int waited;
    checks_cnt = 0;
    fail_cnt   = 0;
    m_active   = 1'b0;
    m_k        = 0;
    m_mask     = 8'h00;
    m_bright   = 4'd0;
    reset      = 1'b0;
    en         = 1'b0;
    digit_mask = 8'hFF;
    bright     = 4'd0;

    // Hold reset for a few cycles, release it, then leave the sequencer idle.
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    ticks = 0;
    fds   = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      ticks += int'(scan_tick);
      fds   += int'(frame_done);
    end
    chk_eq("idle_ticks", 32'(ticks), 32'd0);
    chk_eq("idle_frames", 32'(fds), 32'd0);

    // Enable with every digit unmasked and run just past the first frame wrap.
    en     = 1'b1;
    bright = 4'($urandom_range(0, 15));
    ticks  = 0;
    fds    = 0;
    for (int i = 0; i < 900; i++) begin
      step();
      ticks += int'(scan_tick);
      fds   += int'(frame_done);
    end
    chk_eq("frame1_ticks", 32'(ticks), 32'd9);
    chk_eq("frame1_frames", 32'(fds), 32'd1);

    // Start with an alternating mask, then flip it at random points, including mid-DRIVE.
    digit_mask = 8'b1010_1010;
    for (int i = 0; i < 1600; i++) begin
      step();
      if ($urandom_range(0, 39) == 0) digit_mask = 8'($urandom);
      if ($urandom_range(0, 29) == 0) bright = 4'($urandom_range(0, 15));
    end

    // Drop and restore en at random, including at slot boundaries.
    for (int i = 0; i < 3000; i++) begin
      step();
      if (en && $urandom_range(0, 399) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 2) == 0) en = 1'b1;
      if ($urandom_range(0, 49) == 0) digit_mask = 8'($urandom);
      if ($urandom_range(0, 49) == 0) bright = 4'($urandom_range(0, 15));
    end

    // Assert reset asynchronously while digit 5 is being driven.
    en         = 1'b1;
    digit_mask = 8'hFF;
    bright     = 4'd15;
    waited     = 0;
    while (!(exp_seg == 3'd5 && exp_tick == 1'b0 && exp_anode != 8'hFF) && waited < 2000) begin
      step();
      waited++;
    end
    chk_eq("wait_digit5", 32'(waited < 2000), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_eq("async_anode", 32'(anode), 32'hFF);
    chk_eq("async_seg_sel", 32'(seg_sel), 32'd0);
    chk_eq("async_scan_tick", 32'(scan_tick), 32'd0);
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if ($urandom_range(0, 59) == 0) digit_mask = 8'($urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
